// File: rtl/exec_stage_unit.sv
// Registered Y86 execute stage: operand select, ALU with optional iterative multiply,
// CC register (bit ZF=2, SF=1, OF=0) and condition evaluation behind valid/ready handshakes.
module exec_stage_unit #(
  parameter int unsigned DATA_WID   = 64,
  parameter int unsigned STACK_STEP = 8,
  parameter bit          MUL_EN     = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic [DATA_WID-1:0] valA,
  input  logic [DATA_WID-1:0] valB,
  input  logic [DATA_WID-1:0] valC,
  input  logic [3:0]          dstE,
  input  logic                cc_hold,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] valE,
  output logic                cnd,
  output logic [3:0]          out_dstE,
  output logic [3:0]          out_icode,
  output logic                bad_fun,
  output logic [2:0]          cc_out,
  output logic                busy
);
  localparam int unsigned CNT_W = $clog2(DATA_WID + 1);
  localparam int unsigned MSB   = DATA_WID - 1;
  localparam int unsigned ZF    = 2;
  localparam int unsigned SF    = 1;
  localparam int unsigned OF    = 0;

  localparam logic [3:0] I_RRMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4, I_MRMOV = 4'h5,
                         I_OP    = 4'h6, I_JXX   = 4'h7, I_CALL  = 4'h8, I_RET   = 4'h9,
                         I_PUSH  = 4'hA, I_POP   = 4'hB;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;

  logic [DATA_WID-1:0] op_a, op_b, sum, diff, alu_res, mul_a, mul_b, acc;
  logic [CNT_W-1:0]    count;
  logic [3:0]          mul_icode, mul_dstE;
  logic [2:0]          cc_alu, cc_mul;
  logic                is_op, is_mul, bad_c, cc_wr, cnd_c, add_of, sub_of, alu_of;
  logic                out_free, mul_start, mul_commit, single_load, lt;

  always_comb begin
    case (icode)
      I_OP, I_RRMOV:                 op_a = valA;
      I_RMMOV, I_IRMOV, I_MRMOV:     op_a = valC;
      I_PUSH, I_POP, I_CALL, I_RET:  op_a = DATA_WID'(STACK_STEP);
      default:                       op_a = '0;
    endcase
    case (icode)
      I_OP, I_RMMOV, I_MRMOV, I_PUSH, I_POP, I_CALL, I_RET: op_b = valB;
      default:                                              op_b = '0;
    endcase
  end

  assign is_op  = (icode == I_OP);
  assign is_mul = is_op && (ifun == 4'd4) && MUL_EN;
  assign bad_c  = is_op && (ifun > 4'd3) && !is_mul;
  assign sum    = op_a + op_b;
  assign diff   = op_b - op_a;
  assign add_of = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
  assign sub_of = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_b[MSB]);

  always_comb begin
    alu_res = sum;
    alu_of  = 1'b0;
    cc_wr   = 1'b0;
    if (is_op) begin
      cc_wr = !bad_c && !is_mul;
      case (ifun)
        4'd0:    begin alu_res = sum;  alu_of = add_of; end
        4'd1:    begin alu_res = diff; alu_of = sub_of; end
        4'd2:    alu_res = op_a & op_b;
        4'd3:    alu_res = op_a ^ op_b;
        default: alu_res = '0;
      endcase
    end else if (icode == I_PUSH || icode == I_CALL) begin
      alu_res = diff;
    end
  end

  always_comb begin
    cc_alu     = '0;
    cc_alu[ZF] = (alu_res == '0);
    cc_alu[SF] = alu_res[MSB];
    cc_alu[OF] = alu_of;
    cc_mul     = '0;
    cc_mul[ZF] = (acc == '0);
    cc_mul[SF] = acc[MSB];
  end

  // Conditions read the CC register as it stands at acceptance.
  assign lt = cc_out[SF] ^ cc_out[OF];
  always_comb begin
    cnd_c = 1'b1;
    if (icode == I_RRMOV || icode == I_JXX) begin
      case (ifun)
        4'd0:    cnd_c = 1'b1;
        4'd1:    cnd_c = lt | cc_out[ZF];
        4'd2:    cnd_c = lt;
        4'd3:    cnd_c = cc_out[ZF];
        4'd4:    cnd_c = !cc_out[ZF];
        4'd5:    cnd_c = !lt;
        4'd6:    cnd_c = !lt && !cc_out[ZF];
        default: cnd_c = 1'b0;
      endcase
    end
  end

  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    busy        = 1'b0;
    mul_start   = 1'b0;
    mul_commit  = 1'b0;
    single_load = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = out_free;
        if (in_valid && out_free) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            single_load = 1'b1;
          end
        end
      end
      MUL: begin
        busy = 1'b1;
        if (count == '0 && out_free) begin
          mul_commit = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      count     <= '0;
      mul_icode <= '0;
      mul_dstE  <= '0;
      out_valid <= 1'b0;
      valE      <= '0;
      cnd       <= 1'b0;
      out_dstE  <= 4'hF;
      out_icode <= '0;
      bad_fun   <= 1'b0;
      cc_out    <= 3'b100;
    end else begin
      if (mul_start) begin
        mul_a     <= op_a;
        mul_b     <= op_b;
        acc       <= '0;
        count     <= CNT_W'(DATA_WID);
        mul_icode <= icode;
        mul_dstE  <= dstE;
      end else if (state_q == MUL && count != '0) begin
        if (mul_b[0]) acc <= acc + mul_a;
        mul_a <= mul_a << 1;
        mul_b <= mul_b >> 1;
        count <= count - CNT_W'(1);
      end

      if (single_load) begin
        out_valid <= 1'b1;
        valE      <= alu_res;
        cnd       <= cnd_c;
        out_dstE  <= (icode == I_RRMOV && !cnd_c) ? 4'hF : dstE;
        out_icode <= icode;
        bad_fun   <= bad_c;
      end else if (mul_commit) begin
        out_valid <= 1'b1;
        valE      <= acc;
        cnd       <= 1'b1;
        out_dstE  <= mul_dstE;
        out_icode <= mul_icode;
        bad_fun   <= 1'b0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (single_load && cc_wr && !cc_hold)  cc_out <= cc_alu;
      else if (mul_commit && !cc_hold)       cc_out <= cc_mul;
    end
  end
endmodule
